// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline constants used by the fetch stage.
package rv32_pkg;
  localparam int unsigned     XLEN     = 32;
  localparam logic [31:0]     NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
endpackage

// File: rtl/fetch_unit_hold_buf.sv
// One-entry {pc, inst} holding register that parks a fetched word while
// IF/ID is stalled. Flush has priority over clear, clear over capture.
module fetch_hold_buf #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic            clear_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic            vld_o,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     inst_o
);

  logic            vld_q, vld_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;

  // Next-state: drop the entry on flush or consumption, load it on capture.
  always_comb begin
    vld_d  = vld_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (flush_i || clear_i) begin
      vld_d = 1'b0;
    end else if (capture_i) begin
      vld_d  = 1'b1;
      pc_d   = pc_i;
      inst_d = inst_i;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      vld_q  <= vld_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign vld_o  = vld_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, drives a 1-cycle-latency
// synchronous instruction memory, absorbs stalls through a one-entry hold
// buffer and accepts EX-stage redirects.
module fetch_unit import rv32_pkg::PC_STEP; #(
  parameter int unsigned     XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INST = rv32_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_inst,
  output logic            f_valid,
  output logic            ifid_load
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_vld_q, req_vld_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            issue;
  logic            hold_vld;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic            hold_capture;
  logic            hold_clear;

  assign issue     = rst & ~stall & ~redirect;
  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign ifid_load = ~rst | ~stall | redirect;

  // Park the in-flight response only on the first stall cycle; the entry is
  // consumed on the first non-stalled cycle, when IF/ID loads it.
  assign hold_capture = stall & ~redirect & req_vld_q & ~hold_vld;
  assign hold_clear   = ~stall & hold_vld;

  fetch_hold_buf #(
    .PC_W (XLEN)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .capture_i (hold_capture),
    .clear_i   (hold_clear),
    .flush_i   (redirect),
    .pc_i      (req_pc_q),
    .inst_i    (imem_rdata),
    .vld_o     (hold_vld),
    .pc_o      (hold_pc),
    .inst_o    (hold_inst)
  );

  // PC and in-flight tracking next-state: redirect beats request issue.
  always_comb begin
    pc_d      = pc_q;
    req_vld_d = 1'b0;
    req_pc_d  = req_pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d      = pc_q + XLEN'(PC_STEP);
      req_vld_d = 1'b1;
      req_pc_d  = pc_q;
    end
  end

  // PC and in-flight registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      req_vld_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      req_vld_q <= req_vld_d;
      req_pc_q  <= req_pc_d;
    end
  end

  // Payload select: held word first, then the fresh memory response.
  always_comb begin
    f_valid = 1'b0;
    f_pc    = '0;
    f_inst  = NOP_INST;
    if (rst && !redirect) begin
      if (hold_vld) begin
        f_valid = 1'b1;
        f_pc    = hold_pc;
        f_inst  = hold_inst;
      end else if (req_vld_q) begin
        f_valid = 1'b1;
        f_pc    = req_pc_q;
        f_inst  = imem_rdata;
      end
    end
  end

endmodule
